// File: rtl/btb_assoc_if.sv
// Lookup, update and flush signals of the set-associative branch target buffer.
// The master drives requests; the slave (the BTB) returns registered lookup results.
interface btb_assoc_if #(
  parameter int ADDR_W = 32
);
  logic              flush_i;
  logic              rd_valid_i;
  logic [ADDR_W-1:0] rd_pc_i;
  logic              rd_valid_o;
  logic              rd_hit_o;
  logic              rd_taken_o;
  logic [ADDR_W-1:0] rd_target_o;
  logic              upd_valid_i;
  logic [ADDR_W-1:0] upd_pc_i;
  logic [ADDR_W-1:0] upd_target_i;
  logic              upd_taken_i;

  modport master (
    output flush_i, rd_valid_i, rd_pc_i,
    output upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i,
    input  rd_valid_o, rd_hit_o, rd_taken_o, rd_target_o
  );

  modport slave (
    input  flush_i, rd_valid_i, rd_pc_i,
    input  upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i,
    output rd_valid_o, rd_hit_o, rd_taken_o, rd_target_o
  );
endinterface

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with per-entry saturating direction
// counters and a per-set round-robin victim pointer. Lookups return results
// one cycle later and see the contents from before any same-cycle update.
module btb_assoc #(
  parameter int INDEX_W = 6,
  parameter int WAYS    = 2,
  parameter int CNT_W   = 2,
  parameter int ADDR_W  = 32
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  btb_assoc_if.slave  bus
);

  localparam int SETS  = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - 2;
  localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

  // Entry state: valid, counter and victim pointers are control and reset;
  // tag and target are data, only meaningful when the valid bit is set.
  logic [WAYS-1:0]   valid_q [SETS];
  logic [CNT_W-1:0]  cnt_q   [SETS][WAYS];
  logic [PTR_W-1:0]  vptr_q  [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [ADDR_W-1:0] tgt_q   [SETS][WAYS];

  logic              rd_valid_q,  rd_valid_d;
  logic              rd_hit_q,    rd_hit_d;
  logic              rd_taken_q,  rd_taken_d;
  logic [ADDR_W-1:0] rd_target_q, rd_target_d;

  logic [INDEX_W-1:0] rd_set, upd_set;
  logic [TAG_W-1:0]   rd_tag, upd_tag;
  logic [PTR_W-1:0]   rd_way, upd_hit_way, inv_way, alloc_way, wr_way;
  logic               rd_hit, upd_hit, has_inv;
  logic               upd_en, alloc_en, tgt_we;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - CNT_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (WAYS == 1) return '0;
    return (p == PTR_W'(WAYS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign rd_set  = bus.rd_pc_i[INDEX_W+1:2];
  assign rd_tag  = bus.rd_pc_i[ADDR_W-1:INDEX_W+2];
  assign upd_set = bus.upd_pc_i[INDEX_W+1:2];
  assign upd_tag = bus.upd_pc_i[ADDR_W-1:INDEX_W+2];

  // Lookup tag compare; at most one way can match because allocation only
  // happens after an update miss.
  always_comb begin
    rd_hit = 1'b0;
    rd_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[rd_set][w] && tag_q[rd_set][w] == rd_tag) begin
        rd_hit = 1'b1;
        rd_way = PTR_W'(w);
      end
    end
  end

  // Next lookup result: load on a request, otherwise hold the last result.
  always_comb begin
    rd_valid_d  = bus.rd_valid_i;
    rd_hit_d    = rd_hit_q;
    rd_taken_d  = rd_taken_q;
    rd_target_d = rd_target_q;
    if (bus.rd_valid_i) begin
      rd_hit_d    = rd_hit;
      rd_taken_d  = rd_hit & cnt_q[rd_set][rd_way][CNT_W-1];
      rd_target_d = rd_hit ? tgt_q[rd_set][rd_way] : '0;
    end
  end

  // Update tag compare and victim choice (lowest invalid way, else pointer).
  always_comb begin
    upd_hit     = 1'b0;
    upd_hit_way = '0;
    has_inv     = 1'b0;
    inv_way     = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[upd_set][w] && tag_q[upd_set][w] == upd_tag) begin
        upd_hit     = 1'b1;
        upd_hit_way = PTR_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[upd_set][w]) begin
        has_inv = 1'b1;
        inv_way = PTR_W'(w);
      end
    end
  end

  assign alloc_way = has_inv ? inv_way : vptr_q[upd_set];
  assign wr_way    = upd_hit ? upd_hit_way : alloc_way;
  assign upd_en    = bus.upd_valid_i & ~bus.flush_i;
  assign alloc_en  = upd_en & ~upd_hit & bus.upd_taken_i;
  assign tgt_we    = upd_en & bus.upd_taken_i;

  // Control state: valid bits, counters, victim pointers; flush beats update.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        vptr_q[s]  <= '0;
        for (int w = 0; w < WAYS; w++) cnt_q[s][w] <= '0;
      end
    end else if (bus.flush_i) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        vptr_q[s]  <= '0;
      end
    end else if (upd_en) begin
      if (upd_hit) begin
        cnt_q[upd_set][upd_hit_way] <= bus.upd_taken_i ? sat_inc(cnt_q[upd_set][upd_hit_way])
                                                      : sat_dec(cnt_q[upd_set][upd_hit_way]);
      end else if (alloc_en) begin
        valid_q[upd_set][alloc_way] <= 1'b1;
        cnt_q[upd_set][alloc_way]   <= CNT_WEAK;
        if (!has_inv) vptr_q[upd_set] <= ptr_next(vptr_q[upd_set]);
      end
    end
  end

  // Tag and target storage, written on taken updates (hit or allocation).
  always_ff @(posedge clk_i) begin
    if (tgt_we) begin
      tag_q[upd_set][wr_way] <= upd_tag;
      tgt_q[upd_set][wr_way] <= bus.upd_target_i;
    end
  end

  // Registered lookup result.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_valid_q  <= 1'b0;
      rd_hit_q    <= 1'b0;
      rd_taken_q  <= 1'b0;
      rd_target_q <= '0;
    end else begin
      rd_valid_q  <= rd_valid_d;
      rd_hit_q    <= rd_hit_d;
      rd_taken_q  <= rd_taken_d;
      rd_target_q <= rd_target_d;
    end
  end

  assign bus.rd_valid_o  = rd_valid_q;
  assign bus.rd_hit_o    = rd_hit_q;
  assign bus.rd_taken_o  = rd_taken_q;
  assign bus.rd_target_o = rd_target_q;

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc (INDEX_W=6, WAYS=2, CNT_W=2, ADDR_W=32).
module tb_btb_assoc;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  btb_assoc_if #(.ADDR_W(32)) bus ();

  btb_assoc #(.INDEX_W(6), .WAYS(2), .CNT_W(2), .ADDR_W(32)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus at a falling edge, let the rising edge pass,
  // then drop the strobes at the next falling edge.
  task automatic op(input logic rv, input logic [31:0] rpc,
                    input logic uv, input logic [31:0] upc, input logic [31:0] utgt,
                    input logic utk, input logic fl);
    bus.rd_valid_i   = rv;
    bus.rd_pc_i      = rpc;
    bus.upd_valid_i  = uv;
    bus.upd_pc_i     = upc;
    bus.upd_target_i = utgt;
    bus.upd_taken_i  = utk;
    bus.flush_i      = fl;
    @(negedge clk);
    bus.rd_valid_i  = 1'b0;
    bus.upd_valid_i = 1'b0;
    bus.flush_i     = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    op(1'b0, 32'h0, 1'b1, pc, tgt, tk, 1'b0);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic h,
                         input logic t, input logic [31:0] tgt);
    chk({tag, ".valid"},  32'(bus.rd_valid_o), 32'(v));
    chk({tag, ".hit"},    32'(bus.rd_hit_o),   32'(h));
    chk({tag, ".taken"},  32'(bus.rd_taken_o), 32'(t));
    chk({tag, ".target"}, bus.rd_target_o,     tgt);
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic h, input logic t, input logic [31:0] tgt);
    op(1'b1, pc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk_out(tag, 1'b1, h, t, tgt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    bus.rd_valid_i = 0; bus.rd_pc_i = 0; bus.flush_i = 0;
    bus.upd_valid_i = 0; bus.upd_pc_i = 0; bus.upd_target_i = 0; bus.upd_taken_i = 0;
    rst_n = 1'b0;
    #2;
    chk_out("reset", 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    look("cold", 32'h0000_1000, 1'b0, 1'b0, 32'h0);

    // Allocate, then read back as weakly taken.
    upd(32'h1000, 32'h2000, 1'b1);
    look("alloc", 32'h1000, 1'b1, 1'b1, 32'h2000);
    op(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk_out("hold", 1'b0, 1'b1, 1'b1, 32'h2000);

    // Counter walks down and saturates at 00; not-taken leaves target alone.
    upd(32'h1000, 32'h9999, 1'b0);
    look("nt1", 32'h1000, 1'b1, 1'b0, 32'h2000);
    upd(32'h1000, 32'h9999, 1'b0);
    upd(32'h1000, 32'h9999, 1'b0);
    look("nt3", 32'h1000, 1'b1, 1'b0, 32'h2000);
    upd(32'h1000, 32'h2000, 1'b1);
    look("t1_from0", 32'h1000, 1'b1, 1'b0, 32'h2000);
    // 01 -> 10 -> 11 -> 11 -> 11 with a new target on the way.
    upd(32'h1000, 32'h2000, 1'b1);
    upd(32'h1000, 32'h2000, 1'b1);
    upd(32'h1000, 32'h2000, 1'b1);
    upd(32'h1000, 32'h2400, 1'b1);
    look("sat11", 32'h1000, 1'b1, 1'b1, 32'h2400);
    upd(32'h1000, 32'h0, 1'b0);
    look("dec11", 32'h1000, 1'b1, 1'b1, 32'h2400);
    upd(32'h1000, 32'h0, 1'b0);
    look("dec10", 32'h1000, 1'b1, 1'b0, 32'h2400);

    // Set 0 fills, then round-robin eviction of way 0 then way 1.
    upd(32'h2000, 32'hA000, 1'b1);
    upd(32'h3000, 32'hB000, 1'b1);
    look("evict_1000", 32'h1000, 1'b0, 1'b0, 32'h0);
    look("keep_2000",  32'h2000, 1'b1, 1'b1, 32'hA000);
    look("keep_3000",  32'h3000, 1'b1, 1'b1, 32'hB000);
    look("lowbits",    32'h3003, 1'b1, 1'b1, 32'hB000);
    upd(32'h7000, 32'hE000, 1'b0);
    look("ntmiss",     32'h7000, 1'b0, 1'b0, 32'h0);
    upd(32'h5000, 32'hC000, 1'b1);
    look("evict_2000", 32'h2000, 1'b0, 1'b0, 32'h0);
    look("keep_3000b", 32'h3000, 1'b1, 1'b1, 32'hB000);
    look("keep_5000",  32'h5000, 1'b1, 1'b1, 32'hC000);
    look("other_set",  32'h1004, 1'b0, 1'b0, 32'h0);

    // Same-cycle lookup and allocation: lookup sees the old contents.
    op(1'b1, 32'h4000, 1'b1, 32'h4000, 32'hD000, 1'b1, 1'b0);
    chk_out("rbw_same", 1'b1, 1'b0, 1'b0, 32'h0);
    look("rbw_next",   32'h4000, 1'b1, 1'b1, 32'hD000);
    look("evict_3000", 32'h3000, 1'b0, 1'b0, 32'h0);

    // Flush with simultaneous lookup and update.
    op(1'b1, 32'h4000, 1'b1, 32'h6004, 32'hF000, 1'b1, 1'b1);
    chk_out("flush_same", 1'b1, 1'b1, 1'b1, 32'hD000);
    look("flush_4000", 32'h4000, 1'b0, 1'b0, 32'h0);
    look("flush_6004", 32'h6004, 1'b0, 1'b0, 32'h0);
    look("flush_5000", 32'h5000, 1'b0, 1'b0, 32'h0);

    // Reallocate, then pulse reset while an update is presented.
    upd(32'h4000, 32'hD100, 1'b1);
    look("realloc", 32'h4000, 1'b1, 1'b1, 32'hD100);
    bus.upd_valid_i = 1'b1; bus.upd_pc_i = 32'h8000;
    bus.upd_target_i = 32'h8800; bus.upd_taken_i = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk_out("midreset", 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    bus.upd_valid_i = 1'b0;
    rst_n = 1'b1;
    look("post_rst_4000", 32'h4000, 1'b0, 1'b0, 32'h0);
    look("post_rst_8000", 32'h8000, 1'b0, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
